// File: rtl/cordic_range_reduce_if.sv
// Handshake bundle between angle producer, range reducer and CORDIC consumer.
// Producer and consumer sides share one interface; the reducer sits on the slave modport.
interface cordic_range_reduce_if #(
   parameter int IN_WIDTH   = 24,
   parameter int DATA_WIDTH = 22
);
   logic signed [IN_WIDTH-1:0]   angle_in;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] target_out;
   logic                         negate;
   logic                         out_valid;
   logic                         out_ready;

   modport master (
      output angle_in, in_valid, out_ready,
      input  in_ready, target_out, negate, out_valid
   );

   modport slave (
      input  angle_in, in_valid, out_ready,
      output in_ready, target_out, negate, out_valid
   );
endinterface

// File: rtl/cordic_range_reduce.sv
// Wraps an angle into [-pi,pi] then folds it into [-pi/2,pi/2] with a cosine negate flag.
// Result n+2 edges after accept (n = wrap steps, 0..2); holds output until out_ready, one angle in flight.
module cordic_range_reduce #(
   parameter int IN_INT_WIDTH     = 4,
   parameter int INTEGER_WIDTH    = 2,
   parameter int FRACTIONAL_WIDTH = 20,
   parameter int IN_WIDTH         = IN_INT_WIDTH + FRACTIONAL_WIDTH,
   parameter int DATA_WIDTH       = INTEGER_WIDTH + FRACTIONAL_WIDTH,
   parameter int PI_CONST         = 3294199,
   parameter int HALF_PI_CONST    = 1647099,
   parameter int TWO_PI_CONST     = 6588397
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  clk_en,
   cordic_range_reduce_if.slave io
);
   localparam logic signed [IN_WIDTH-1:0] PI_W       = IN_WIDTH'(PI_CONST);
   localparam logic signed [IN_WIDTH-1:0] NEG_PI_W   = IN_WIDTH'(-PI_CONST);
   localparam logic signed [IN_WIDTH-1:0] HALF_W     = IN_WIDTH'(HALF_PI_CONST);
   localparam logic signed [IN_WIDTH-1:0] NEG_HALF_W = IN_WIDTH'(-HALF_PI_CONST);
   localparam logic signed [IN_WIDTH-1:0] TWO_PI_W   = IN_WIDTH'(TWO_PI_CONST);

   typedef enum logic [1:0] {IDLE, WRAP, FOLD, OUT} state_t;

   state_t                       state, state_nxt;
   logic signed [IN_WIDTH-1:0]   w, w_nxt;
   logic signed [IN_WIDTH-1:0]   fold_val;
   logic signed [DATA_WIDTH-1:0] target, target_nxt;
   logic                         neg, neg_nxt;
   logic                         valid, valid_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         w      <= '0;
         target <= '0;
         neg    <= 1'b0;
         valid  <= 1'b0;
      end else if (clk_en) begin
         state  <= state_nxt;
         w      <= w_nxt;
         target <= target_nxt;
         neg    <= neg_nxt;
         valid  <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      w_nxt      = w;
      target_nxt = target;
      neg_nxt    = neg;
      valid_nxt  = valid;
      fold_val   = '0;
      case (state)
         IDLE: begin
            if (io.in_valid) begin
               w_nxt     = io.angle_in;
               state_nxt = WRAP;
            end
         end
         WRAP: begin
            // each step moves w toward zero, so the subtraction cannot overflow
            if (w > PI_W)          w_nxt = w - TWO_PI_W;
            else if (w < NEG_PI_W) w_nxt = w + TWO_PI_W;
            else                   state_nxt = FOLD;
         end
         FOLD: begin
            if (w > HALF_W) begin
               fold_val = PI_W - w;
               neg_nxt  = 1'b1;
            end else if (w < NEG_HALF_W) begin
               fold_val = NEG_PI_W - w;
               neg_nxt  = 1'b1;
            end else begin
               fold_val = w;
               neg_nxt  = 1'b0;
            end
            // |fold_val| <= pi/2, so dropping the upper integer bits is lossless
            target_nxt = DATA_WIDTH'(fold_val);
            valid_nxt  = 1'b1;
            state_nxt  = OUT;
         end
         OUT: begin
            if (io.out_ready) begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign io.in_ready   = rst & clk_en & (state == IDLE);
   assign io.out_valid  = valid & clk_en;
   assign io.target_out = target;
   assign io.negate     = neg;
endmodule

// File: tb/tb_cordic_range_reduce.sv
// Randomized and directed bench for cordic_range_reduce against an integer reference model.
module tb_cordic_range_reduce;
   localparam int PI      = 3294199;
   localparam int HALF_PI = 1647099;
   localparam int TWO_PI  = 6588397;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clk_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   cordic_range_reduce_if #(.IN_WIDTH(24), .DATA_WIDTH(22)) io ();

   cordic_range_reduce dut (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .io     (io.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: reduce modulo 2*pi into [-pi,pi], then reflect about +-pi/2.
   function automatic void model(input int ang, output int tgt, output int neg, output int nwrap);
      int a;
      a     = ang;
      nwrap = 0;
      while ((a > PI || a < -PI) && nwrap < 8) begin
         a = (a > 0) ? a - TWO_PI : a + TWO_PI;
         nwrap++;
      end
      if (a > HALF_PI) begin
         tgt = PI - a;  neg = 1;
      end else if (a < -HALF_PI) begin
         tgt = -PI - a; neg = 1;
      end else begin
         tgt = a;       neg = 0;
      end
   endfunction

   // Sends one angle; hold = cycles out_ready stays low after out_valid,
   // stall_at = edges after accept at which clk_en drops for 3 cycles (0 = never).
   task automatic run_one(input int ang, input int hold, input int stall_at, input string tag);
      int exp_t, exp_n, nw, lat, tries, held_t;
      model(ang, exp_t, exp_n, nw);
      @(negedge clk);
      io.out_ready = (hold == 0);
      io.angle_in  = 24'(ang);
      io.in_valid  = 1'b1;
      tries = 0;
      while (!io.in_ready && tries < 10) begin
         @(negedge clk);
         tries++;
      end
      if (!io.in_ready) begin
         chk({tag, " accept_timeout"}, 0, 1);
         io.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 io.in_valid = 1'b0;
      lat = 0;
      while (lat < 30) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (stall_at != 0 && lat == stall_at) begin
            clk_en = 1'b0;
            repeat (3) begin
               @(posedge clk);
               lat++;
               @(negedge clk);
            end
            chk({tag, " stall_in_ready"}, int'(io.in_ready), 0);
            clk_en = 1'b1;
         end
         if (io.out_valid) break;
      end
      if (!io.out_valid) begin
         chk({tag, " valid_timeout"}, 0, 1);
         return;
      end
      chk({tag, " latency"}, lat, nw + 2 + ((stall_at != 0) ? 3 : 0));
      chk({tag, " target"}, int'(io.target_out), exp_t);
      chk({tag, " negate"}, int'(io.negate), exp_n);
      chk({tag, " busy_in_ready"}, int'(io.in_ready), 0);
      if (hold > 0) begin
         held_t = int'(io.target_out);
         repeat (hold) @(negedge clk);
         if (hold >= 2) begin
            clk_en = 1'b0;
            #1 chk({tag, " gated_valid"}, int'(io.out_valid), 0);
            @(negedge clk);
            clk_en = 1'b1;
            #1;
         end
         chk({tag, " hold_valid"}, int'(io.out_valid), 1);
         chk({tag, " hold_target"}, int'(io.target_out), held_t);
         chk({tag, " hold_in_ready"}, int'(io.in_ready), 0);
         io.out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk({tag, " drained_valid"}, int'(io.out_valid), 0);
      chk({tag, " ready_again"}, int'(io.in_ready), 1);
   endtask

   initial begin
      int seen;
      logic [23:0] r;
      io.angle_in  = '0;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      clk_en       = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst out_valid", int'(io.out_valid), 0);
      chk("rst in_ready", int'(io.in_ready), 0);
      chk("rst target", int'(io.target_out), 0);
      chk("rst negate", int'(io.negate), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle in_ready", int'(io.in_ready), 1);

      run_one(0, 0, 0, "zero");
      run_one(2097152, 0, 0, "two");
      run_one(7340032, 0, 0, "seven");
      run_one(-8388608, 0, 0, "minus_eight");
      run_one(8388607, 0, 0, "max");
      run_one(PI, 5, 0, "pi_hold");
      run_one(-PI, 0, 0, "neg_pi");
      run_one(PI + 1, 0, 0, "pi_plus1");
      run_one(HALF_PI, 0, 0, "half_pi");
      run_one(-HALF_PI, 0, 0, "neg_half_pi");
      run_one(HALF_PI + 1, 0, 0, "half_pi_plus1");
      run_one(7340032, 0, 1, "stall_wrap");

      // reset mid-WRAP must drop the in-flight angle without emitting anything
      @(negedge clk);
      io.angle_in = 24'(7340032);
      io.in_valid = 1'b1;
      @(posedge clk);
      #1 io.in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("midrst out_valid", int'(io.out_valid), 0);
      chk("midrst in_ready", int'(io.in_ready), 0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (io.out_valid) seen++;
      end
      chk("midrst stale_output", seen, 0);
      chk("midrst idle", int'(io.in_ready), 1);
      run_one(-8388608, 0, 0, "after_rst");

      for (int i = 0; i < 150; i++) begin
         r = 24'($urandom);
         run_one(int'($signed(r)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0) ? 1 : 0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/cordic_range_reduce.md
Name: cordic_range_reduce

Overview:
- Upstream front end of the unrolled 16-stage cosine CORDIC pipeline.
- Takes an arbitrary signed angle in radians, wraps it into [-pi, pi], then folds it into [-pi/2, pi/2], the convergence range of the pipeline.
- Emits the folded 2.20 target plus a negate flag. A downstream consumer delays the flag by the pipeline latency and flips the sign of the cosine result.
- Uses a valid/ready handshake on both sides and a small iterative state machine.

Parameters:
- IN_INT_WIDTH, 4, integer bits of the input angle, including sign.
- INTEGER_WIDTH, 2, integer bits of the output target, including sign.
- FRACTIONAL_WIDTH, 20, fractional bits on both sides.
- IN_WIDTH, IN_INT_WIDTH+FRACTIONAL_WIDTH (24), input angle width.
- DATA_WIDTH, INTEGER_WIDTH+FRACTIONAL_WIDTH (22), output target width.
- PI_CONST, 3294199, pi in Q.20.
- HALF_PI_CONST, 1647099, pi/2 in Q.20.
- TWO_PI_CONST, 6588397, 2*pi in Q.20.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clk_en  in  1  global enable; low freezes the block.
- angle_in  in  IN_WIDTH  signed angle in radians, range [-8, 8).
- in_valid  in  1  angle_in is valid.
- in_ready  out  1  block can accept an angle.
- target_out  out  DATA_WIDTH  folded angle in [-pi/2, pi/2]; feeds the CORDIC target input.
- negate  out  1  cosine of angle_in equals minus the cosine of target_out.
- out_valid  out  1  target_out and negate are valid.
- out_ready  in  1  consumer accepts the output.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, work register=0, target_out=0, negate=0, out_valid=0. in_ready=0 while in reset.
- All arithmetic is signed two's complement on an IN_WIDTH work register w. Every add/subtract moves w toward zero, so no overflow is possible.
- States:
  - IDLE: in_ready=clk_en. On an edge with clk_en & in_valid, latch w=angle_in and go to WRAP.
  - WRAP: one step per edge. If w>PI_CONST, w-=TWO_PI_CONST. Else if w<-PI_CONST, w+=TWO_PI_CONST. Else go to FOLD with w unchanged. At most 2 wrap steps are needed for the input range.
  - FOLD, one edge, outputs registered:
    - w>HALF_PI_CONST: target_out=PI_CONST-w, negate=1.
    - w<-HALF_PI_CONST: target_out=-PI_CONST-w, negate=1.
    - otherwise: target_out=w, negate=0.
    - Then out_valid=1, go to OUT.
    - Truncate the result to DATA_WIDTH bits; it is lossless because |result| <= pi/2.
  - OUT: target_out, negate and out_valid are held stable. An edge with clk_en & out_ready goes to IDLE and clears out_valid. There is no accept in the same cycle; in_ready rises on the following cycle.
- Latency: with n wrap steps, out_valid rises n+2 edges after the accept edge (2 to 4 cycles). Throughput is one result per n+4 cycles when out_ready is held high.
- Boundary cases:
  - w==PI_CONST: no wrap; fold gives target_out=0, negate=1.
  - w==-PI_CONST: target_out=0, negate=1.
  - w==±HALF_PI_CONST: passes through unchanged, negate=0.
- clk_en=0:
  - No state, register or output changes.
  - in_ready forced 0.
  - The out_valid port is gated to 0 externally; the internal flag is retained.
  - No handshake completes on either side.
- Reset mid-operation discards the angle in flight; no output is produced for it.
- in_valid while the block is not in IDLE is ignored. The producer must hold angle_in stable until in_ready.

Test Plan:
- angle_in=0, out_ready=1 -> out_valid rises 2 cycles after accept; target_out=0, negate=0; in_ready back high 1 cycle later.
- angle_in=2097152 (2.0) -> no wrap; target_out=1197047, negate=1; latency 2.
- angle_in=7340032 (7.0) -> one wrap (w=751635), then target_out=751635, negate=0; latency 3.
- angle_in=-8388608 (-8.0) -> one wrap (w=-1800211), then target_out=-1493988, negate=1; latency 3.
- angle_in=3294199 (exactly pi), out_ready held 0 for 5 cycles -> target_out=0, negate=1, out_valid stays high and outputs stable; in_ready=0 until 1 cycle after out_ready rises.
- Reset/enable:
  - Drop clk_en for 3 cycles mid-WRAP -> result is identical to the unstalled result, delayed 3 cycles.
  - Assert rst low mid-WRAP -> out_valid=0 immediately, state returns to IDLE, no stale output afterwards.
